// File: rtl/sprite_color_mapper_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_color_mapper_if
// Brief    : Host sprite-table write port, pixel input stream and colour output
//            stream of the sprite colour mapper.
// Revision : 1.0  initial release
// ============================================================================
interface sprite_color_mapper_if #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 10,
   parameter int SIZE_W      = 10,
   parameter int COLOR_W     = 8
);
   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   logic                   frame_start;
   logic                   spr_we;
   logic [IDX_W-1:0]       spr_idx;
   logic [COORD_W-1:0]     spr_x;
   logic [COORD_W-1:0]     spr_y;
   logic [SIZE_W-1:0]      spr_size;
   logic                   spr_shape;
   logic                   spr_en;
   logic [3*COLOR_W-1:0]   spr_rgb;
   logic                   pix_valid_in;
   logic [COORD_W-1:0]     draw_x;
   logic [COORD_W-1:0]     draw_y;
   logic                   pix_valid_out;
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic [COLOR_W-1:0]     red;
   logic [COLOR_W-1:0]     green;
   logic [COLOR_W-1:0]     blue;
   logic                   commit_pending;

   modport master (
      output frame_start, spr_we, spr_idx, spr_x, spr_y, spr_size, spr_shape,
             spr_en, spr_rgb, pix_valid_in, draw_x, draw_y,
      input  pix_valid_out, hit, hit_idx, red, green, blue, commit_pending
   );

   modport slave (
      input  frame_start, spr_we, spr_idx, spr_x, spr_y, spr_size, spr_shape,
             spr_en, spr_rgb, pix_valid_in, draw_x, draw_y,
      output pix_valid_out, hit, hit_idx, red, green, blue, commit_pending
   );
endinterface
`default_nettype wire

// File: rtl/sprite_color_mapper.sv
`default_nettype none
// ============================================================================
// Module   : sprite_color_mapper
// Brief    : 3-stage pixel colour generator, double-buffered sprite table over
//            a gradient background. Define SPRITE_CIRCLE_EN for circle sprites.
// Revision : 1.0  initial release
// ============================================================================
module sprite_color_mapper #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 10,
   parameter int SIZE_W      = 10,
   parameter int COLOR_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sprite_color_mapper_if.slave bus
);
   localparam int IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int c_RGB_W  = 3 * COLOR_W;
   localparam int c_DIFF_W = COORD_W + 1;
   localparam int c_CMP_W  = (c_DIFF_W > SIZE_W) ? c_DIFF_W : SIZE_W;
`ifdef SPRITE_CIRCLE_EN
   localparam int c_SQ_W   = (2*COORD_W+3 > 2*SIZE_W) ? 2*COORD_W+3 : 2*SIZE_W;
`endif

   // Shadow / active sprite tables
   logic [COORD_W-1:0] r_sh_x    [NUM_SPRITES];
   logic [COORD_W-1:0] r_sh_y    [NUM_SPRITES];
   logic [SIZE_W-1:0]  r_sh_size [NUM_SPRITES];
   logic               r_sh_en   [NUM_SPRITES];
   logic [c_RGB_W-1:0] r_sh_rgb  [NUM_SPRITES];
   logic [COORD_W-1:0] r_act_x   [NUM_SPRITES];
   logic [COORD_W-1:0] r_act_y   [NUM_SPRITES];
   logic [SIZE_W-1:0]  r_act_size[NUM_SPRITES];
   logic               r_act_en  [NUM_SPRITES];
   logic [c_RGB_W-1:0] r_act_rgb [NUM_SPRITES];
   logic [COORD_W-1:0] w_nx_x    [NUM_SPRITES];
   logic [COORD_W-1:0] w_nx_y    [NUM_SPRITES];
   logic [SIZE_W-1:0]  w_nx_size [NUM_SPRITES];
   logic               w_nx_en   [NUM_SPRITES];
   logic [c_RGB_W-1:0] w_nx_rgb  [NUM_SPRITES];
`ifdef SPRITE_CIRCLE_EN
   logic               r_sh_circ [NUM_SPRITES];
   logic               r_act_circ[NUM_SPRITES];
   logic               w_nx_circ [NUM_SPRITES];
   logic               r1_circ   [NUM_SPRITES];
`endif
   logic               w_wr_ok;
   logic               r_pending;

   // Stage registers
   logic signed [c_DIFF_W-1:0] r1_dx   [NUM_SPRITES];
   logic signed [c_DIFF_W-1:0] r1_dy   [NUM_SPRITES];
   logic [SIZE_W-1:0]          r1_size [NUM_SPRITES];
   logic                       r1_en   [NUM_SPRITES];
   logic [c_RGB_W-1:0]         r1_rgb  [NUM_SPRITES];
   logic                       r1_valid;
   logic [3:0]                 r1_fx, r1_fy;
   logic [NUM_SPRITES-1:0]     w_hit;
   logic [NUM_SPRITES-1:0]     r2_hit;
   logic [c_RGB_W-1:0]         r2_rgb  [NUM_SPRITES];
   logic                       r2_valid;
   logic [3:0]                 r2_fx, r2_fy;
   logic                       w_win;
   logic [IDX_W-1:0]           w_win_idx;
   logic [c_RGB_W-1:0]         w_win_rgb;
   logic [COLOR_W-1:0]         w_bg_g, w_bg_b;

   assign w_wr_ok = bus.spr_we && (32'(bus.spr_idx) < NUM_SPRITES);

   // A same-cycle write is merged here so a commit picks it up.
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_nx_x[i]    = r_sh_x[i];
         w_nx_y[i]    = r_sh_y[i];
         w_nx_size[i] = r_sh_size[i];
         w_nx_en[i]   = r_sh_en[i];
         w_nx_rgb[i]  = r_sh_rgb[i];
`ifdef SPRITE_CIRCLE_EN
         w_nx_circ[i] = r_sh_circ[i];
`endif
         if (w_wr_ok && (bus.spr_idx == IDX_W'(i))) begin
            w_nx_x[i]    = bus.spr_x;
            w_nx_y[i]    = bus.spr_y;
            w_nx_size[i] = bus.spr_size;
            w_nx_en[i]   = bus.spr_en;
            w_nx_rgb[i]  = bus.spr_rgb;
`ifdef SPRITE_CIRCLE_EN
            w_nx_circ[i] = bus.spr_shape;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_sh_x[i]     <= '0;
            r_sh_y[i]     <= '0;
            r_sh_size[i]  <= '0;
            r_sh_en[i]    <= 1'b0;
            r_sh_rgb[i]   <= '0;
            r_act_x[i]    <= '0;
            r_act_y[i]    <= '0;
            r_act_size[i] <= '0;
            r_act_en[i]   <= 1'b0;
            r_act_rgb[i]  <= '0;
`ifdef SPRITE_CIRCLE_EN
            r_sh_circ[i]  <= 1'b0;
            r_act_circ[i] <= 1'b0;
`endif
         end
         r_pending <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_sh_x[i]    <= w_nx_x[i];
            r_sh_y[i]    <= w_nx_y[i];
            r_sh_size[i] <= w_nx_size[i];
            r_sh_en[i]   <= w_nx_en[i];
            r_sh_rgb[i]  <= w_nx_rgb[i];
`ifdef SPRITE_CIRCLE_EN
            r_sh_circ[i] <= w_nx_circ[i];
`endif
            if (bus.frame_start) begin
               r_act_x[i]    <= w_nx_x[i];
               r_act_y[i]    <= w_nx_y[i];
               r_act_size[i] <= w_nx_size[i];
               r_act_en[i]   <= w_nx_en[i];
               r_act_rgb[i]  <= w_nx_rgb[i];
`ifdef SPRITE_CIRCLE_EN
               r_act_circ[i] <= w_nx_circ[i];
`endif
            end
         end
         if (bus.frame_start)
            r_pending <= 1'b0;
         else if (w_wr_ok)
            r_pending <= 1'b1;
      end
   end

   assign bus.commit_pending = r_pending;

   // S1 snapshots the slot attributes with the differences so a commit
   // never mixes old and new table entries within one in-flight pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r1_dx[i]   <= '0;
            r1_dy[i]   <= '0;
            r1_size[i] <= '0;
            r1_en[i]   <= 1'b0;
            r1_rgb[i]  <= '0;
`ifdef SPRITE_CIRCLE_EN
            r1_circ[i] <= 1'b0;
`endif
         end
         r1_valid <= 1'b0;
         r1_fx    <= '0;
         r1_fy    <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r1_dx[i]   <= $signed({1'b0, bus.draw_x}) - $signed({1'b0, r_act_x[i]});
            r1_dy[i]   <= $signed({1'b0, bus.draw_y}) - $signed({1'b0, r_act_y[i]});
            r1_size[i] <= r_act_size[i];
            r1_en[i]   <= r_act_en[i];
            r1_rgb[i]  <= r_act_rgb[i];
`ifdef SPRITE_CIRCLE_EN
            r1_circ[i] <= r_act_circ[i];
`endif
         end
         r1_valid <= bus.pix_valid_in;
         r1_fx    <= bus.draw_x[6:3];
         r1_fy    <= bus.draw_y[6:3];
      end
   end

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
      logic [c_DIFF_W-1:0] w_adx, w_ady;
      logic                w_box;
      assign w_adx = r1_dx[i][c_DIFF_W-1] ? $unsigned(-r1_dx[i]) : $unsigned(r1_dx[i]);
      assign w_ady = r1_dy[i][c_DIFF_W-1] ? $unsigned(-r1_dy[i]) : $unsigned(r1_dy[i]);
      assign w_box = (c_CMP_W'(w_adx) <= c_CMP_W'(r1_size[i])) &&
                     (c_CMP_W'(w_ady) <= c_CMP_W'(r1_size[i]));
`ifdef SPRITE_CIRCLE_EN
      logic [c_SQ_W-1:0] w_d2, w_r2;
      assign w_d2 = c_SQ_W'(w_adx) * c_SQ_W'(w_adx) + c_SQ_W'(w_ady) * c_SQ_W'(w_ady);
      assign w_r2 = c_SQ_W'(r1_size[i]) * c_SQ_W'(r1_size[i]);
      assign w_hit[i] = r1_en[i] && (r1_circ[i] ? (w_d2 <= w_r2) : w_box);
`else
      assign w_hit[i] = r1_en[i] && w_box;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++)
            r2_rgb[i] <= '0;
         r2_hit   <= '0;
         r2_valid <= 1'b0;
         r2_fx    <= '0;
         r2_fy    <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++)
            r2_rgb[i] <= r1_rgb[i];
         r2_hit   <= w_hit;
         r2_valid <= r1_valid;
         r2_fx    <= r1_fx;
         r2_fy    <= r1_fy;
      end
   end

   // Walking downwards leaves the lowest hitting index as the winner.
   always_comb begin
      w_win     = 1'b0;
      w_win_idx = '0;
      w_win_rgb = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (r2_hit[i]) begin
            w_win     = 1'b1;
            w_win_idx = IDX_W'(i);
            w_win_rgb = r2_rgb[i];
         end
      end
   end

   if (COLOR_W == 8) begin : g_bg_8
      assign w_bg_g = COLOR_W'(8'hBF - {4'h0, r2_fx});
      assign w_bg_b = COLOR_W'(8'h7F - {4'h0, r2_fy});
   end else begin : g_bg_scaled
      localparam logic [COLOR_W-1:0] c_BG_G = COLOR_W'((32'hBF << COLOR_W) >> 8);
      localparam logic [COLOR_W-1:0] c_BG_B = COLOR_W'((32'h7F << COLOR_W) >> 8);
      assign w_bg_g = c_BG_G - COLOR_W'((32'(r2_fx) << COLOR_W) >> 4);
      assign w_bg_b = c_BG_B - COLOR_W'((32'(r2_fy) << COLOR_W) >> 4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pix_valid_out <= 1'b0;
         bus.hit           <= 1'b0;
         bus.hit_idx       <= '0;
         bus.red           <= '0;
         bus.green         <= '0;
         bus.blue          <= '0;
      end else begin
         bus.pix_valid_out <= r2_valid;
         if (!r2_valid) begin
            bus.hit     <= 1'b0;
            bus.hit_idx <= '0;
            bus.red     <= '0;
            bus.green   <= '0;
            bus.blue    <= '0;
         end else if (w_win) begin
            bus.hit     <= 1'b1;
            bus.hit_idx <= w_win_idx;
            bus.red     <= w_win_rgb[c_RGB_W-1 -: COLOR_W];
            bus.green   <= w_win_rgb[2*COLOR_W-1 -: COLOR_W];
            bus.blue    <= w_win_rgb[COLOR_W-1:0];
         end else begin
            bus.hit     <= 1'b0;
            bus.hit_idx <= '0;
            bus.red     <= '0;
            bus.green   <= w_bg_g;
            bus.blue    <= w_bg_b;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sprite_color_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_color_mapper
// Brief    : Directed scoreboard bench for sprite_color_mapper (3 slots so an
//            out-of-range slot index is representable).
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_color_mapper;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          vec_id = 0;

   typedef struct {
      int unsigned due;
      int          id;
      logic        hit;
      logic [1:0]  idx;
      logic [23:0] rgb;
   } exp_t;
   exp_t exp_q[$];

   sprite_color_mapper_if #(.NUM_SPRITES(3), .COORD_W(10), .SIZE_W(10), .COLOR_W(8)) bus ();

   sprite_color_mapper #(.NUM_SPRITES(3), .COORD_W(10), .SIZE_W(10), .COLOR_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clr();
      bus.spr_we       = 1'b0;
      bus.frame_start  = 1'b0;
      bus.pix_valid_in = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic wr(input int idx, input int x, input int y, input int size,
                     input logic shp, input logic en, input logic [23:0] rgb, input logic fs);
      tick();
      bus.spr_we      = 1'b1;
      bus.spr_idx     = 2'(idx);
      bus.spr_x       = 10'(x);
      bus.spr_y       = 10'(y);
      bus.spr_size    = 10'(size);
      bus.spr_shape   = shp;
      bus.spr_en      = en;
      bus.spr_rgb     = rgb;
      bus.frame_start = fs;
   endtask

   task automatic commit();
      tick();
      bus.frame_start = 1'b1;
   endtask

   task automatic pix(input int x, input int y, input logic h, input int idx, input logic [23:0] rgb);
      exp_t e;
      tick();
      bus.pix_valid_in = 1'b1;
      bus.draw_x       = 10'(x);
      bus.draw_y       = 10'(y);
      e.due = cyc + 3;
      e.id  = vec_id;
      e.hit = h;
      e.idx = 2'(idx);
      e.rgb = rgb;
      exp_q.push_back(e);
      vec_id++;
   endtask

   task automatic chk_pending(input string name, input logic exp);
      tick();
      chk(name, 64'(bus.commit_pending), 64'(exp));
   endtask

   initial begin
      clr();
      bus.spr_idx = '0; bus.spr_x = '0; bus.spr_y = '0; bus.spr_size = '0;
      bus.spr_shape = 1'b0; bus.spr_en = 1'b0; bus.spr_rgb = '0;
      bus.draw_x = '0; bus.draw_y = '0;

      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (rst_n) begin
                  if (bus.pix_valid_out) begin
                     if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", 64'(bus.pix_valid_out), 64'(0));
                     end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("pixel%0d", e.id),
                            {37'b0, bus.hit, bus.hit_idx, bus.red, bus.green, bus.blue},
                            {37'b0, e.hit, e.idx, e.rgb});
                        chk($sformatf("latency%0d", e.id), 64'(cyc), 64'(e.due));
                     end
                  end else begin
                     chk("blanking", {37'b0, bus.hit, bus.hit_idx, bus.red, bus.green, bus.blue}, 64'(0));
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("reset_outputs", {36'b0, bus.pix_valid_out, bus.hit, bus.hit_idx, bus.red, bus.green, bus.blue}, 64'(0));
      chk("reset_pending", 64'(bus.commit_pending), 64'(0));

      // Mid-stream reset flushes in-flight pixels
      pix(0, 0, 0, 0, 24'h00BF7F);
      pix(8, 8, 0, 0, 24'h00BE7E);
      pix(127, 64, 0, 0, 24'h00B077);
      pix(120, 0, 0, 0, 24'h00B07F);
      tick();
      chk("pre_reset_valid", 64'(bus.pix_valid_out), 64'(1));
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("async_reset_outputs", {36'b0, bus.pix_valid_out, bus.hit, bus.hit_idx, bus.red, bus.green, bus.blue}, 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      pix(16, 24, 0, 0, 24'h00BD7C);
      tick();

      // Box boundary
      wr(0, 100, 100, 8, 1'b0, 1'b1, 24'hFA61E8, 1'b0);
      commit();
      pix(108, 92, 1, 0, 24'hFA61E8);
      pix(109, 92, 0, 0, 24'h00B274);
      pix(92, 108, 1, 0, 24'hFA61E8);
      pix(91, 100, 0, 0, 24'h00B473);
      tick();

      // Overlap priority and commit timing
      wr(0, 50, 50, 4, 1'b0, 1'b1, 24'h111111, 1'b0);
      wr(2, 50, 50, 6, 1'b0, 1'b1, 24'h222222, 1'b0);
      commit();
      pix(50, 50, 1, 0, 24'h111111);
      pix(55, 50, 1, 2, 24'h222222);
      chk_pending("pending_after_commit", 1'b0);
      wr(0, 50, 50, 4, 1'b0, 1'b0, 24'h111111, 1'b0);
      pix(50, 50, 1, 0, 24'h111111);
      bus.frame_start = 1'b1;
      pix(50, 50, 1, 2, 24'h222222);
      tick();

      // Shadow write without commit, then write+commit in one cycle
      wr(1, 300, 300, 3, 1'b0, 1'b1, 24'h333333, 1'b0);
      chk_pending("pending_after_write", 1'b1);
      pix(300, 300, 0, 0, 24'h00BA7A);
      wr(1, 300, 300, 3, 1'b0, 1'b1, 24'h444444, 1'b1);
      chk_pending("pending_write_and_commit", 1'b0);
      pix(300, 300, 1, 1, 24'h444444);
      pix(304, 300, 0, 0, 24'h00B97A);
      tick();

      // Circle versus box
      wr(1, 200, 200, 10, 1'b1, 1'b1, 24'h555555, 1'b1);
      pix(206, 208, 1, 1, 24'h555555);
`ifdef SPRITE_CIRCLE_EN
      pix(207, 208, 0, 0, 24'h00B675);
`else
      pix(207, 208, 1, 1, 24'h555555);
`endif
      pix(200, 190, 1, 1, 24'h555555);
      pix(211, 200, 0, 0, 24'h00B576);
      tick();

      // Edge coordinates and out-of-range slot index
      wr(2, 0, 20, 5, 1'b0, 1'b1, 24'h666666, 1'b1);
      pix(3, 20, 1, 2, 24'h666666);
      pix(1021, 20, 0, 0, 24'h00B07D);
      chk_pending("pending_clean", 1'b0);
      wr(3, 3, 20, 9, 1'b0, 1'b1, 24'h777777, 1'b0);
      chk_pending("pending_bad_idx", 1'b0);
      commit();
      pix(3, 20, 1, 2, 24'h666666);
      tick();

      repeat (6) tick();
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
